// File: rtl/mvm_load_sequencer.sv
// Streams RF weight lines for N consecutive routers, then the input vector, onto the MVM NoC AXIS slave port.
// Latency: 3 cycles per beat (RD, CAP, SEND) at full M_TREADY; a stall holds SEND with the payload frozen.
module mvm_load_sequencer #(
  parameter int DATAW     = 512,
  parameter int USERW     = 75,
  parameter int DESTW     = 12,
  parameter int IDW       = 32,
  parameter int NUM_DEST  = 15,
  parameter int RF_DEPTH  = 64,
  parameter int VEC_BEATS = 1,
  parameter int WAW       = $clog2(NUM_DEST*RF_DEPTH),
  parameter int VAW       = ($clog2(VEC_BEATS) > 0) ? $clog2(VEC_BEATS) : 1
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          START,
  input  logic [$clog2(NUM_DEST+1)-1:0] CFG_NUM_DEST,
  input  logic [DESTW-1:0]              CFG_FIRST_DEST,
  input  logic [DESTW-1:0]              CFG_VEC_DEST,
  input  logic                          CFG_LOAD_WEIGHTS,
  output logic                          BUSY,
  output logic                          DONE,
  output logic                          WGT_RD_EN,
  output logic [WAW-1:0]                WGT_RD_ADDR,
  input  logic [DATAW-1:0]              WGT_RD_DATA,
  output logic                          VEC_RD_EN,
  output logic [VAW-1:0]                VEC_RD_ADDR,
  input  logic [DATAW-1:0]              VEC_RD_DATA,
  output logic                          M_TVALID,
  input  logic                          M_TREADY,
  output logic [DATAW-1:0]              M_TDATA,
  output logic [IDW-1:0]                M_TID,
  output logic [DESTW-1:0]              M_TDEST,
  output logic [USERW-1:0]              M_TUSER,
  output logic                          M_TLAST
);

  localparam int NDW = $clog2(NUM_DEST+1);
  localparam int LW  = $clog2(RF_DEPTH);

  typedef enum logic [2:0] {
    IDLE, W_RD, W_CAP, W_SEND, V_RD, V_CAP, V_SEND, FIN
  } state_t;

  state_t             state_q, state_d;
  logic [NDW-1:0]     num_dest_q, num_dest_d;
  logic [DESTW-1:0]   first_dest_q, first_dest_d;
  logic [DESTW-1:0]   vec_dest_q, vec_dest_d;
  logic [NDW-1:0]     router_idx_q, router_idx_d;
  logic [LW-1:0]      line_q, line_d;
  logic [VAW-1:0]     vbeat_q, vbeat_d;
  logic               m_tvalid_q, m_tvalid_d;
  logic [DATAW-1:0]   m_tdata_q, m_tdata_d;
  logic [DESTW-1:0]   m_tdest_q, m_tdest_d;
  logic [USERW-1:0]   m_tuser_q, m_tuser_d;

  logic [NDW:0]       cfg_num_wide;
  logic [NDW-1:0]     cfg_num_clamped;
  logic [RF_DEPTH-1:0] line_onehot;
  logic               wgt_rd_en;
  logic               vec_rd_en;

  always_comb begin
    // Widened so the clamp compare stays meaningful when NUM_DEST fills the field.
    cfg_num_wide    = {1'b0, CFG_NUM_DEST};
    cfg_num_clamped = (cfg_num_wide > (NDW+1)'(NUM_DEST)) ? NDW'(NUM_DEST) : CFG_NUM_DEST;
    line_onehot         = '0;
    line_onehot[line_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    num_dest_d   = num_dest_q;
    first_dest_d = first_dest_q;
    vec_dest_d   = vec_dest_q;
    router_idx_d = router_idx_q;
    line_d       = line_q;
    vbeat_d      = vbeat_q;
    m_tvalid_d   = m_tvalid_q;
    m_tdata_d    = m_tdata_q;
    m_tdest_d    = m_tdest_q;
    m_tuser_d    = m_tuser_q;
    wgt_rd_en    = 1'b0;
    vec_rd_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          num_dest_d   = cfg_num_clamped;
          first_dest_d = CFG_FIRST_DEST;
          vec_dest_d   = CFG_VEC_DEST;
          router_idx_d = '0;
          line_d       = '0;
          vbeat_d      = '0;
          state_d      = (CFG_LOAD_WEIGHTS && (cfg_num_clamped != '0)) ? W_RD : V_RD;
        end
      end
      W_RD: begin
        wgt_rd_en = 1'b1;
        state_d   = W_CAP;
      end
      W_CAP: begin
        m_tdata_d  = WGT_RD_DATA;
        m_tdest_d  = first_dest_q + DESTW'(router_idx_q);
        m_tuser_d  = USERW'({line_onehot, 2'b11, 9'h001});
        m_tvalid_d = 1'b1;
        state_d    = W_SEND;
      end
      W_SEND: begin
        if (M_TREADY) begin
          m_tvalid_d = 1'b0;
          m_tuser_d  = '0;
          if (line_q != LW'(RF_DEPTH-1)) begin
            line_d  = line_q + LW'(1);
            state_d = W_RD;
          end else if ((router_idx_q + NDW'(1)) < num_dest_q) begin
            line_d       = '0;
            router_idx_d = router_idx_q + NDW'(1);
            state_d      = W_RD;
          end else begin
            state_d = V_RD;
          end
        end
      end
      V_RD: begin
        vec_rd_en = 1'b1;
        state_d   = V_CAP;
      end
      V_CAP: begin
        m_tdata_d  = VEC_RD_DATA;
        m_tdest_d  = vec_dest_q;
        m_tuser_d  = USERW'({2'b10, 9'h000});
        m_tvalid_d = 1'b1;
        state_d    = V_SEND;
      end
      V_SEND: begin
        if (M_TREADY) begin
          m_tvalid_d = 1'b0;
          m_tuser_d  = '0;
          if (vbeat_q != VAW'(VEC_BEATS-1)) begin
            vbeat_d = vbeat_q + VAW'(1);
            state_d = V_RD;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      num_dest_q   <= '0;
      first_dest_q <= '0;
      vec_dest_q   <= '0;
      router_idx_q <= '0;
      line_q       <= '0;
      vbeat_q      <= '0;
      m_tvalid_q   <= 1'b0;
      m_tdata_q    <= '0;
      m_tdest_q    <= '0;
      m_tuser_q    <= '0;
    end else begin
      state_q      <= state_d;
      num_dest_q   <= num_dest_d;
      first_dest_q <= first_dest_d;
      vec_dest_q   <= vec_dest_d;
      router_idx_q <= router_idx_d;
      line_q       <= line_d;
      vbeat_q      <= vbeat_d;
      m_tvalid_q   <= m_tvalid_d;
      m_tdata_q    <= m_tdata_d;
      m_tdest_q    <= m_tdest_d;
      m_tuser_q    <= m_tuser_d;
    end
  end

  assign BUSY        = (state_q != IDLE);
  assign DONE        = (state_q == FIN);
  assign WGT_RD_EN   = wgt_rd_en;
  assign WGT_RD_ADDR = WAW'(router_idx_q) * WAW'(RF_DEPTH) + WAW'(line_q);
  assign VEC_RD_EN   = vec_rd_en;
  assign VEC_RD_ADDR = vbeat_q;
  assign M_TVALID    = m_tvalid_q;
  assign M_TDATA     = m_tdata_q;
  assign M_TID       = '0;
  assign M_TDEST     = m_tdest_q;
  assign M_TUSER     = m_tuser_q;
  // Every beat is its own single-flit packet.
  assign M_TLAST     = m_tvalid_q;

endmodule

// File: tb/tb_mvm_load_sequencer.sv
// Directed-plus-random bench for mvm_load_sequencer against a beat-list reference model.
module tb_mvm_load_sequencer;

  localparam int RF = 64;

  typedef struct packed {
    logic [511:0] data;
    logic [11:0]  dest;
    logic [74:0]  user;
  } beat_t;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic         START;
  logic [3:0]   CFG_NUM_DEST;
  logic [11:0]  CFG_FIRST_DEST;
  logic [11:0]  CFG_VEC_DEST;
  logic         CFG_LOAD_WEIGHTS;
  logic         BUSY, DONE;
  logic         WGT_RD_EN;
  logic [9:0]   WGT_RD_ADDR;
  logic [511:0] WGT_RD_DATA;
  logic         VEC_RD_EN;
  logic [0:0]   VEC_RD_ADDR;
  logic [511:0] VEC_RD_DATA;
  logic         M_TVALID, M_TREADY, M_TLAST;
  logic [511:0] M_TDATA;
  logic [31:0]  M_TID;
  logic [11:0]  M_TDEST;
  logic [74:0]  M_TUSER;

  always #5 CLK = ~CLK;

  mvm_load_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .CFG_NUM_DEST(CFG_NUM_DEST), .CFG_FIRST_DEST(CFG_FIRST_DEST),
    .CFG_VEC_DEST(CFG_VEC_DEST), .CFG_LOAD_WEIGHTS(CFG_LOAD_WEIGHTS),
    .BUSY(BUSY), .DONE(DONE),
    .WGT_RD_EN(WGT_RD_EN), .WGT_RD_ADDR(WGT_RD_ADDR), .WGT_RD_DATA(WGT_RD_DATA),
    .VEC_RD_EN(VEC_RD_EN), .VEC_RD_ADDR(VEC_RD_ADDR), .VEC_RD_DATA(VEC_RD_DATA),
    .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TID(M_TID),
    .M_TDEST(M_TDEST), .M_TUSER(M_TUSER), .M_TLAST(M_TLAST)
  );

  logic [479:0] wkey;
  logic [511:0] vec_word;

  // SRAM models: one-cycle read latency, word = salted address / random vector.
  always @(posedge CLK) begin
    if (WGT_RD_EN) WGT_RD_DATA <= {wkey, 22'b0, WGT_RD_ADDR};
    if (VEC_RD_EN) VEC_RD_DATA <= vec_word ^ 512'(VEC_RD_ADDR);
  end

  int    n_assert = 0;
  int    n_fail   = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    done_cnt, wrd_cnt, vrd_cnt, stall_err, tlast_err, busy_cyc, done_cyc;
  bit    timed_out, aborted;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic build_exp(input int n, input logic [11:0] fd, input logic [11:0] vd, input logic lw);
    beat_t b;
    int ne;
    exp_q.delete();
    ne = (n > 15) ? 15 : n;
    if (lw) begin
      for (int r = 0; r < ne; r++) begin
        for (int l = 0; l < RF; l++) begin
          b.data = {wkey, 22'b0, 10'(r*RF + l)};
          b.dest = fd + 12'(r);
          b.user = (75'(1) << (11 + l)) | (75'(3) << 9) | 75'(1);
          exp_q.push_back(b);
        end
      end
    end
    b.data = vec_word;
    b.dest = vd;
    b.user = 75'(2) << 9;
    exp_q.push_back(b);
  endtask

  task automatic run_seq(input int n, input logic [11:0] fd, input logic [11:0] vd, input logic lw,
                         input int stall_pct, input int restart_at, input int abort_at);
    int cyc, max_cyc, post;
    bit prev_stall, restarted, rdy;
    beat_t b, prev_b;
    obs_q.delete();
    done_cnt = 0; wrd_cnt = 0; vrd_cnt = 0; stall_err = 0; tlast_err = 0;
    busy_cyc = -1; done_cyc = -1; timed_out = 0; aborted = 0;
    wkey     = {$urandom, $urandom, $urandom, $urandom, 352'(0)} ^ 480'($urandom);
    vec_word = {16{$urandom}};
    build_exp(n, fd, vd, lw);
    max_cyc = 3 * (n * RF + 1) * 4 + 50;
    @(negedge CLK);
    CFG_NUM_DEST = 4'(n); CFG_FIRST_DEST = fd; CFG_VEC_DEST = vd; CFG_LOAD_WEIGHTS = lw;
    START = 1'b1; M_TREADY = 1'b1;
    cyc = 0; post = -1; prev_stall = 0; restarted = 0; prev_b = '0;
    forever begin
      @(negedge CLK);
      START = 1'b0;
      cyc++;
      b = {M_TDATA, M_TDEST, M_TUSER};
      if (BUSY && busy_cyc < 0) busy_cyc = cyc;
      if (DONE) begin
        done_cnt++;
        done_cyc = cyc;
        if (post < 0) post = 0;
      end
      if (WGT_RD_EN) wrd_cnt++;
      if (VEC_RD_EN) vrd_cnt++;
      if (prev_stall && (!M_TVALID || b !== prev_b)) stall_err++;
      if (abort_at >= 0 && M_TVALID && obs_q.size() == abort_at) begin
        RST_N = 1'b0;
        #1;
        aborted = 1;
        break;
      end
      if (restart_at >= 0 && !restarted && M_TVALID && obs_q.size() == restart_at) begin
        START = 1'b1;
        CFG_NUM_DEST = 4'($urandom_range(1, 15));
        CFG_FIRST_DEST = 12'($urandom);
        CFG_VEC_DEST = 12'($urandom);
        restarted = 1;
      end
      rdy = ($urandom_range(0, 99) >= stall_pct);
      M_TREADY = rdy;
      if (M_TVALID && rdy) begin
        obs_q.push_back(b);
        if (M_TLAST !== 1'b1 || M_TID !== 32'h0) tlast_err++;
      end
      prev_stall = M_TVALID && !rdy;
      prev_b = b;
      if (post >= 0) begin
        if (post == 6) break;
        post++;
      end
      if (cyc > max_cyc) begin
        timed_out = 1;
        break;
      end
    end
    START = 1'b0;
  endtask

  task automatic check_beats(input string tag, input bit full);
    int m;
    chk({tag, "_timeout"}, 64'(timed_out), 64'(0));
    if (full) chk({tag, "_nbeats"}, 64'(obs_q.size()), 64'(exp_q.size()));
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      n_assert++;
      assert (obs_q[i] === exp_q[i]) else begin
        n_fail++;
        $error("FAIL %s_beat[%0d]: got %h expected %h", tag, i, obs_q[i], exp_q[i]);
      end
    end
    chk({tag, "_stall_stable"}, 64'(stall_err), 64'(0));
    chk({tag, "_tlast_tid"}, 64'(tlast_err), 64'(0));
  endtask

  initial begin
    int n;
    RST_N = 1'b0; START = 1'b0; M_TREADY = 1'b0;
    CFG_NUM_DEST = '0; CFG_FIRST_DEST = '0; CFG_VEC_DEST = '0; CFG_LOAD_WEIGHTS = 1'b0;
    WGT_RD_DATA = '0; VEC_RD_DATA = '0; wkey = '0; vec_word = '0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(BUSY), 64'(0));
    chk("rst_done", 64'(DONE), 64'(0));
    chk("rst_tvalid", 64'(M_TVALID), 64'(0));
    chk("rst_rden", 64'({WGT_RD_EN, VEC_RD_EN}), 64'(0));
    chk("rst_payload", 64'({|M_TDATA, |M_TUSER, |M_TDEST, M_TLAST, |M_TID}), 64'(0));
    RST_N = 1'b1;

    // Two-router load at full rate
    run_seq(2, 12'h001, 12'h001, 1'b1, 0, -1, -1);
    check_beats("s1", 1);
    chk("s1_done_cnt", 64'(done_cnt), 64'(1));
    chk("s1_latency", 64'(done_cyc - busy_cyc + 1), 64'(388));
    chk("s1_wgt_reads", 64'(wrd_cnt), 64'(128));
    chk("s1_vec_reads", 64'(vrd_cnt), 64'(1));
    chk("s1_busy_end", 64'(BUSY), 64'(0));

    // Random back-pressure
    run_seq(2, 12'($urandom), 12'($urandom), 1'b1, 30, -1, -1);
    check_beats("s2", 1);
    chk("s2_done_cnt", 64'(done_cnt), 64'(1));
    chk("s2_wgt_reads", 64'(wrd_cnt), 64'(128));

    // Weight phase skipped two ways
    run_seq(2, 12'h010, 12'h0A5, 1'b0, 0, -1, -1);
    check_beats("s3a", 1);
    chk("s3a_wgt_reads", 64'(wrd_cnt), 64'(0));
    chk("s3a_latency", 64'(done_cyc - busy_cyc + 1), 64'(4));
    run_seq(0, 12'h010, 12'h05A, 1'b1, 0, -1, -1);
    check_beats("s3b", 1);
    chk("s3b_wgt_reads", 64'(wrd_cnt), 64'(0));
    chk("s3b_done_cnt", 64'(done_cnt), 64'(1));

    // START pulse while a weight beat is pending
    run_seq(2, 12'h123, 12'h456, 1'b1, 20, 5, -1);
    check_beats("s4", 1);
    chk("s4_done_cnt", 64'(done_cnt), 64'(1));
    chk("s4_busy_end", 64'(BUSY), 64'(0));

    // Reset while router 1, line 20 is on the bus
    run_seq(2, 12'h001, 12'h001, 1'b1, 0, -1, RF + 20);
    chk("s5_aborted", 64'(aborted), 64'(1));
    check_beats("s5_pre", 0);
    chk("s5_nbeats", 64'(obs_q.size()), 64'(RF + 20));
    chk("s5_rst_tvalid", 64'(M_TVALID), 64'(0));
    chk("s5_rst_ctl", 64'({BUSY, DONE, WGT_RD_EN, VEC_RD_EN, M_TLAST}), 64'(0));
    chk("s5_rst_payload", 64'({|M_TDATA, |M_TUSER, |M_TDEST, |WGT_RD_ADDR}), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    run_seq(2, 12'h001, 12'h001, 1'b1, 0, -1, -1);
    check_beats("s5_rerun", 1);
    chk("s5_rerun_latency", 64'(done_cyc - busy_cyc + 1), 64'(388));

    // Destination wraps modulo 2^12
    run_seq(2, 12'hFFF, 12'h800, 1'b1, 0, -1, -1);
    check_beats("s6", 1);
    if (obs_q.size() > RF) begin
      chk("s6_dest_r0", 64'(obs_q[0].dest), 64'(12'hFFF));
      chk("s6_dest_r1", 64'(obs_q[RF].dest), 64'(12'h000));
    end else begin
      chk("s6_short", 64'(obs_q.size()), 64'(2 * RF + 1));
    end

    // Random router count with random stalls
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 4);
      run_seq(n, 12'($urandom), 12'($urandom), 1'b1, $urandom_range(0, 50), -1, -1);
      check_beats("s7", 1);
      chk("s7_wgt_reads", 64'(wrd_cnt), 64'(n * RF));
      chk("s7_done_cnt", 64'(done_cnt), 64'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
